// File: rtl/reset_seq_pkg.sv
// rtl/reset_seq_pkg.sv - shared types for the reset sequencer
package reset_seq_pkg;

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        CAUSE_POR       = 2'd0,
        CAUSE_LOCK_LOSS = 2'd1,
        CAUSE_SW        = 2'd2
    } cause_e;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/reset_seq_if.sv
// rtl/reset_seq_if.sv - lock/request inputs and domain reset outputs of reset_seq
// Optional RESET_SEQ_CAUSE_EN adds the cause signal.
interface reset_seq_if #(
    parameter int NUM_LOCKS   = 1,
    parameter int NUM_DOMAINS = 2
);
    logic [NUM_LOCKS-1:0]   locked_async;
    logic                   sw_reset_req;
    logic [NUM_DOMAINS-1:0] resets;
    logic                   ready;
`ifdef RESET_SEQ_CAUSE_EN
    logic [1:0]             cause;

    modport master (
        output locked_async, sw_reset_req,
        input  resets, ready, cause
    );
    modport slave (
        input  locked_async, sw_reset_req,
        output resets, ready, cause
    );
`else
    modport master (
        output locked_async, sw_reset_req,
        input  resets, ready
    );
    modport slave (
        input  locked_async, sw_reset_req,
        output resets, ready
    );
`endif
endinterface

// File: rtl/reset_seq_sync_n.sv
// rtl/reset_seq_sync_n.sv - single-bit multi-stage synchroniser, cleared to 0 in reset
module sync_n #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] ff;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ff <= '0;
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];
endmodule

// File: rtl/reset_seq.sv
// rtl/reset_seq.sv - lock-gated staggered domain reset sequencer with software reset
// Optional RESET_SEQ_CAUSE_EN records the cause of the last reset.
module reset_seq
    import reset_seq_pkg::*;
#(
    parameter int NUM_LOCKS      = 1,
    parameter int NUM_DOMAINS    = 2,
    parameter int HOLD_CYCLES    = 15,
    parameter int STAGGER_CYCLES = 4,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       resetn,
    reset_seq_if.slave bus
);
    localparam int CNT_W = $clog2(max2(HOLD_CYCLES, STAGGER_CYCLES) + 1);
    localparam int IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

    logic [NUM_LOCKS-1:0]   synced;
    logic                   all_locked;
    state_e                 state;
    logic [CNT_W-1:0]       count;
    logic [IDX_W-1:0]       idx;
    logic [NUM_DOMAINS-1:0] resets_q;
    logic                   ready_q;

    for (genvar i = 0; i < NUM_LOCKS; i++) begin : g_sync
        sync_n #(.STAGES(SYNC_STAGES)) u_sync (
            .clk    (clk),
            .resetn (resetn),
            .d      (bus.locked_async[i]),
            .q      (synced[i])
        );
    end

    assign all_locked = &synced;

    // Loss of lock or a software request pre-empts every state on the same edge.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= ST_HOLD;
            count    <= '0;
            idx      <= '0;
            resets_q <= '1;
            ready_q  <= 1'b0;
        end else if (!all_locked || bus.sw_reset_req) begin
            state    <= ST_HOLD;
            count    <= '0;
            idx      <= '0;
            resets_q <= '1;
            ready_q  <= 1'b0;
        end else begin
            case (state)
                ST_HOLD: begin
                    resets_q <= '1;
                    ready_q  <= 1'b0;
                    if (count == CNT_W'(HOLD_CYCLES - 1)) begin
                        resets_q[0] <= 1'b0;
                        count       <= '0;
                        if (NUM_DOMAINS == 1) begin
                            state   <= ST_RUN;
                            ready_q <= 1'b1;
                        end else begin
                            state <= ST_RELEASE;
                            idx   <= IDX_W'(1);
                        end
                    end else begin
                        count <= count + CNT_W'(1);
                    end
                end
                ST_RELEASE: begin
                    if (count == CNT_W'(STAGGER_CYCLES - 1)) begin
                        resets_q[idx] <= 1'b0;
                        count         <= '0;
                        if (idx == IDX_W'(NUM_DOMAINS - 1)) begin
                            state   <= ST_RUN;
                            ready_q <= 1'b1;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end else begin
                        count <= count + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    resets_q <= '0;
                    ready_q  <= 1'b1;
                end
                default: begin
                    state    <= ST_HOLD;
                    count    <= '0;
                    idx      <= '0;
                    resets_q <= '1;
                    ready_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.resets = resets_q;
    assign bus.ready  = ready_q;

`ifdef RESET_SEQ_CAUSE_EN
    cause_e cause_q;

    // A low lock in HOLD at count 0 is still the initial wait, not a loss.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cause_q <= CAUSE_POR;
        end else if (!all_locked && (state != ST_HOLD || count != '0)) begin
            cause_q <= CAUSE_LOCK_LOSS;
        end else if (bus.sw_reset_req) begin
            cause_q <= CAUSE_SW;
        end
    end

    assign bus.cause = cause_q;
`endif
endmodule

// File: doc/reset_seq.md
Name: reset_seq

Overview:
- Parametrised reset controller for multi-domain SoC tops.
- Synchronises N asynchronous PLL/oscillator lock inputs and holds all domains in reset until every lock has been stable for HOLD_CYCLES.
- Then releases NUM_DOMAINS active-high domain resets in a fixed staggered order, and accepts a software reset request.
- Sits between the PLL(s) and the core/peripheral clusters. Replaces ad-hoc per-top reset counters.

Parameters:
- NUM_LOCKS, 1, number of asynchronous lock inputs; all must be high to leave reset.
- NUM_DOMAINS, 2, number of domain reset outputs, released in index order 0..NUM_DOMAINS-1.
- HOLD_CYCLES, 15, consecutive cycles of synced all-locked required before the first release; must be ≥1.
- STAGGER_CYCLES, 4, cycles between successive domain releases; must be ≥1.
- SYNC_STAGES, 2, flop stages per lock synchroniser; must be ≥2.

Ports:
- clk, input, 1, single clock; all logic is clocked on its rising edge.
- resetn, input, 1, synchronous active-low reset.
- locked_async, input, NUM_LOCKS, asynchronous lock indications.
- sw_reset_req, input, 1, synchronous software reset request; a one-cycle pulse suffices.
- resets, output, NUM_DOMAINS, active-high domain resets.
- ready, output, 1, high when all domains are released.
- cause, output, 2, last reset cause; present only with RESET_SEQ_CAUSE_EN.

Behaviour:
- Clock and reset:
  - One clock. Reset is synchronous and active-low.
  - resetn low at an edge: state=HOLD, count=0, idx=0, resets=all 1s, ready=0, synchroniser flops=0.
- Lock synchronisation:
  - Each locked_async bit passes through SYNC_STAGES flops.
  - all_locked = AND of the synced bits.
- Counter width: $clog2(max(HOLD_CYCLES,STAGGER_CYCLES)+1). The counter never wraps; it is cleared on every state change.
- HOLD state:
  - resets all 1, ready 0.
  - all_locked=1: count increments.
  - all_locked=0: count clears.
  - all_locked=1 and count==HOLD_CYCLES-1: clear resets[0]. Go to RUN if NUM_DOMAINS==1, otherwise go to RELEASE with idx=1 and count=0.
- RELEASE state:
  - count increments each cycle.
  - At count==STAGGER_CYCLES-1: clear resets[idx] and set count=0.
  - If idx==NUM_DOMAINS-1, go to RUN; otherwise idx+1.
- RUN state: resets all 0, ready 1.
  - ready rises on the same edge that clears resets[NUM_DOMAINS-1].
- Abort (any state, highest after resetn):
  - all_locked=0 or sw_reset_req=1 at an edge: next state HOLD, count=0, resets all 1, ready 0. Takes effect on that same edge.
  - sw_reset_req held high keeps the block in HOLD with count=0.
- Latency with locks stable high from resetn release (edge 1 = first edge with resetn high):
  - all_locked is first high after edge SYNC_STAGES.
  - resets[0] falls after edge SYNC_STAGES+HOLD_CYCLES.
  - resets[i] falls STAGGER_CYCLES edges after resets[i-1].
- Lock glitch: a glitch shorter than one cycle may be missed by the synchroniser. This is acceptable. Any captured low restarts HOLD from count 0.
- Reset mid-operation: resetn low in RELEASE or RUN reasserts every reset immediately at that edge.

Optional Feature:
- Macro: RESET_SEQ_CAUSE_EN.
- Defined: the cause output exists.
  - 2'd0 POR: set by resetn.
  - 2'd1 LOCK_LOSS: all_locked falls while not in HOLD, or is seen low during HOLD with count>0.
  - 2'd2 SW: set by sw_reset_req.
  - Simultaneous events: resetn beats LOCK_LOSS, which beats SW.
  - Updated only on the abort edge. Stable otherwise, including through RUN.
- Undefined: the port and register are absent. Sequencing behaviour is identical.

Decomposition:
- Package reset_seq_pkg:
  - state enum HOLD/RELEASE/RUN.
  - cause enum POR/LOCK_LOSS/SW (2 bits).
- Sub-module sync_n: SYNC_STAGES-deep single-bit synchroniser with synchronous active-low reset to 0. Instantiated NUM_LOCKS times.
- The top-level sequencer FSM and counter live in reset_seq.

Test Plan (NUM_LOCKS=2, NUM_DOMAINS=3, HOLD=15, STAGGER=4, SYNC=2):
- Power-up:
  - Stimulus: locks both high, resetn released before edge 1.
  - Response: resets=3'b111 through edge 16; 3'b110 after edge 17; 3'b100 after 21; 3'b000 and ready=1 after 25.
- Late second lock:
  - Stimulus: locked_async[1] rises 10 cycles later than [0].
  - Response: all timings shift by exactly 10 edges.
- Lock loss in RUN:
  - Stimulus: in RUN, drop locked_async[0] for 3 cycles.
  - Response: resets=3'b111 and ready=0 two edges after the drop; after the lock returns, full sequence replays with identical timing; cause=1.
- Software pulse mid-release:
  - Stimulus: 1-cycle sw_reset_req while resets=3'b110.
  - Response: resets=3'b111 on the next edge; restart, with resets[0] falling 15 edges after the pulse; cause=2.
- resetn mid-sequence:
  - Stimulus: resetn low for 1 cycle in RUN.
  - Response: resets=3'b111, ready=0, cause=0; the resync delay of 2 edges is observed again.
- Short glitch in HOLD:
  - Stimulus: in HOLD at count 10, locked_async[1] low for 1 cycle.
  - Response: count restarts; release occurs 15 edges after all_locked returns high.
